calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Top-level control FSM for the two-function calculator.
- Watches keypad key events and the two's-complement operand from the input unit.
- Captures operand A, the function, and operand B, then starts the arithmetic unit and waits for it to finish.
- Holds the result for the display and clears the keypad entry buffer between operands.

Parameters:
- N, 8, operand width (two's complement).
- RW, 16, result width.
- TIMEOUT, 255, maximum cycles spent waiting for alu_done before an error is flagged.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_trig  in  1  key-press strobe from the keypad scanner; may stay high for more than one cycle.
- key_val  in  4  code of the pressed key: 0-9 digit, A = function 0, B = function 1, C/D unused, E = clear, F = equals.
- operand  in  N  current entry in two's complement.
- alu_done  in  1  one-cycle completion pulse from the arithmetic unit.
- alu_result  in  RW  result from the arithmetic unit; valid while alu_done is high.
- alu_err  in  1  arithmetic error (overflow or divide-by-zero); valid while alu_done is high.
- alu_a  out  N  latched operand A.
- alu_b  out  N  latched operand B.
- alu_op  out  1  latched function select.
- alu_start  out  1  one-cycle start pulse.
- entry_clr  out  1  one-cycle pulse that clears the keypad digit buffer.
- result  out  RW  held result.
- result_valid  out  1  high while a result is displayed.
- err  out  1  error flag; high while in SHOW with an error.
- state  out  3  current state encoding, for debug.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = S_A (0).
  - alu_a, alu_b, alu_op, result = 0.
  - alu_start, entry_clr, result_valid, err = 0.
- Key event: the rising edge of key_trig, registered internally (key_q). A high level lasting several cycles counts as one event. The event is acted on in the cycle after the edge is sampled; FSM latency is one clock from the sampled edge.
- States: S_A = 0, S_B = 1, S_START = 2, S_WAIT = 3, S_SHOW = 4. Encodings 5-7 are illegal and go to S_A on the next clock.
- S_A:
  - Key A or B: alu_a <= operand, alu_op <= key_val[0], pulse entry_clr, go to S_B.
  - Digits, C, D and F: ignored; digits are handled by the keypad unit.
- S_B:
  - Key F: alu_b <= operand, go to S_START.
  - Key A or B: alu_op is overwritten; no clear, stay in S_B.
  - Digits: ignored.
- S_START: alu_start = 1 for exactly one cycle, timeout counter cleared, go to S_WAIT.
- S_WAIT:
  - alu_done = 1: result <= alu_result, err <= alu_err, go to S_SHOW.
  - Otherwise the counter increments. When it reaches TIMEOUT with no done: err <= 1, result <= 0, go to S_SHOW.
  - Key events other than E: ignored.
- S_SHOW:
  - result_valid = 1; result and err are held.
  - Digits, A, B and F: ignored.
  - E: go to S_A.
- Clear key E, in any state:
  - Next state S_A, entry_clr pulsed.
  - result_valid, err, result, alu_a, alu_b, alu_op return to 0; alu_start forced to 0.
- Priority:
  - E in the same cycle as alu_done: clear wins and the done is discarded.
  - A late alu_done arriving in any state other than S_WAIT is ignored.
- entry_clr and alu_start are never high in the same cycle. Each is a single-cycle pulse; neither ever lasts two cycles.
- Arithmetic: no arithmetic is done here. Operands pass through unmodified, with sign preserved.
- Timeout counter: width is ceil(log2(TIMEOUT+1)), saturating, and active only in S_WAIT.

Test Plan:
- Reset held low mid-S_WAIT with operand = 8'h05 → on the next edge all outputs are 0 and state = 0; alu_done pulses after release have no effect.
- Simple operation:
  - Stimulus: operand = 8'h0C, key A; operand = 8'hFD (-3), key F.
  - Required: alu_a = 0x0C, alu_op = 0, alu_b = 0xFD, one entry_clr pulse after A, alu_start for one cycle two clocks after the F event.
  - Then alu_done with alu_result = 16'h0009 → result = 0x0009, result_valid = 1, err = 0.
- key_trig held high for 10 cycles with key A in S_A → exactly one entry_clr pulse and one transition to S_B.
- Function change in S_B: key A then key B → alu_op = 1, no second entry_clr, state remains 1.
- Timeout: TIMEOUT = 16, no alu_done → after 16 cycles in S_WAIT: err = 1, result = 0, result_valid = 1; a later alu_done is ignored.
- Clear versus done: key E in the same cycle as alu_done (result 16'h1234) → state = 0, result = 0, result_valid = 0, entry_clr pulsed once.

Source files
------------

// File: rtl/calc_sequencer.sv
// Control sequencer for the two-function calculator: captures A, function and B,
// runs the arithmetic unit and holds its result for the display.
module calc_sequencer #(
  parameter int N       = 8,
  parameter int RW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_trig,
  input  logic [3:0]    key_val,
  input  logic [N-1:0]  operand,
  input  logic          alu_done,
  input  logic [RW-1:0] alu_result,
  input  logic          alu_err,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic          alu_op,
  output logic          alu_start,
  output logic          entry_clr,
  output logic [RW-1:0] result,
  output logic          result_valid,
  output logic          err,
  output logic [2:0]    state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_B     = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_SHOW  = 3'd4
  } state_t;

  state_t        cur;
  logic          key_q;
  logic          key_evt;
  logic [3:0]    key_code;
  logic [CW-1:0] cnt;
  logic          is_clr;
  logic          is_fn;
  logic          is_eq;

  assign state = cur;

  // Edge-detect the strobe and register it with its key code; the FSM acts one clock later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q    <= 1'b0;
      key_evt  <= 1'b0;
      key_code <= 4'h0;
    end else begin
      key_q    <= key_trig;
      key_evt  <= key_trig & ~key_q;
      key_code <= key_val;
    end
  end

  assign is_clr = key_evt && (key_code == 4'hE);
  assign is_fn  = key_evt && (key_code[3:1] == 3'b101);
  assign is_eq  = key_evt && (key_code == 4'hF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur          <= S_A;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= 1'b0;
      alu_start    <= 1'b0;
      entry_clr    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      cnt          <= '0;
    end else begin
      alu_start <= 1'b0;
      entry_clr <= 1'b0;
      // Clear overrides everything, including a done arriving in the same cycle.
      if (is_clr) begin
        cur          <= S_A;
        entry_clr    <= 1'b1;
        alu_a        <= '0;
        alu_b        <= '0;
        alu_op       <= 1'b0;
        result       <= '0;
        result_valid <= 1'b0;
        err          <= 1'b0;
        cnt          <= '0;
      end else begin
        case (cur)
          S_A: begin
            if (is_fn) begin
              alu_a     <= operand;
              alu_op    <= key_code[0];
              entry_clr <= 1'b1;
              cur       <= S_B;
            end
          end
          S_B: begin
            if (is_eq) begin
              alu_b     <= operand;
              alu_start <= 1'b1;
              cur       <= S_START;
            end else if (is_fn) begin
              alu_op <= key_code[0];
            end
          end
          S_START: begin
            cnt <= '0;
            cur <= S_WAIT;
          end
          S_WAIT: begin
            if (alu_done) begin
              result       <= alu_result;
              err          <= alu_err;
              result_valid <= 1'b1;
              cur          <= S_SHOW;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
              result       <= '0;
              err          <= 1'b1;
              result_valid <= 1'b1;
              cur          <= S_SHOW;
            end else if (cnt != {CW{1'b1}}) begin
              cnt <= cnt + 1'b1;
            end
          end
          S_SHOW: begin
            cur <= S_SHOW;
          end
          default: begin
            cur <= S_A;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a result scoreboard and pulse monitors.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_trig = 1'b0;
  logic [3:0]  key_val = 4'h0;
  logic [7:0]  operand = 8'h00;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'h0;
  logic        alu_err = 1'b0;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_op;
  logic        alu_start;
  logic        entry_clr;
  logic [15:0] result;
  logic        result_valid;
  logic        err;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;
  int start_cnt = 0;
  int overlap_cnt = 0;
  int long_cnt = 0;
  logic clr_prev = 1'b0;
  logic start_prev = 1'b0;

  typedef struct {
    logic [15:0] res;
    logic        er;
  } exp_t;
  exp_t sb[$];

  calc_sequencer #(.N(8), .RW(16), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .key_trig(key_trig), .key_val(key_val),
    .operand(operand), .alu_done(alu_done), .alu_result(alu_result),
    .alu_err(alu_err), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_start(alu_start), .entry_clr(entry_clr), .result(result),
    .result_valid(result_valid), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (entry_clr) clr_cnt++;
      if (alu_start) start_cnt++;
      if (entry_clr && alu_start) overlap_cnt++;
      if ((entry_clr && clr_prev) || (alu_start && start_prev)) long_cnt++;
      clr_prev   = entry_clr;
      start_prev = alu_start;
    end else begin
      clr_prev   = 1'b0;
      start_prev = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe high across exactly one rising edge; returns at the following negedge.
  task automatic press(input logic [3:0] k);
    key_val  = k;
    key_trig = 1'b1;
    @(negedge clk);
    key_trig = 1'b0;
  endtask

  task automatic pulse_done(input logic [15:0] r, input logic e);
    alu_result = r;
    alu_err    = e;
    alu_done   = 1'b1;
    @(negedge clk);
    alu_done   = 1'b0;
  endtask

  task automatic wait_show_and_score(input string tag);
    exp_t e;
    for (int i = 0; i < 100 && !result_valid; i++) @(negedge clk);
    check({tag, "_show_reached"}, {31'd0, result_valid}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_result"}, {16'd0, result}, {16'd0, e.res});
      check({tag, "_err"}, {31'd0, err}, {31'd0, e.er});
    end else begin
      check({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    int c0;
    int wait_cycles;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_outputs", {alu_a, alu_b, 7'd0, alu_op, 4'd0, alu_start, entry_clr, result_valid, err}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Simple operation: 0x0C op0 0xFD
    operand = 8'h0C;
    press(4'hA);
    @(negedge clk);
    check("a_state", {29'd0, state}, 32'd1);
    check("a_alu_a", {24'd0, alu_a}, 32'h0C);
    check("a_alu_op", {31'd0, alu_op}, 32'd0);
    check("a_entry_clr", {31'd0, entry_clr}, 32'd1);
    @(negedge clk);
    check("a_entry_clr_end", {31'd0, entry_clr}, 32'd0);
    operand = 8'hFD;
    press(4'hF);
    check("f_still_b", {29'd0, state}, 32'd1);
    @(negedge clk);
    check("f_state_start", {29'd0, state}, 32'd2);
    check("f_alu_start", {31'd0, alu_start}, 32'd1);
    check("f_alu_b", {24'd0, alu_b}, 32'hFD);
    @(negedge clk);
    check("wait_state", {29'd0, state}, 32'd3);
    check("start_end", {31'd0, alu_start}, 32'd0);
    sb.push_back('{res: 16'h0009, er: 1'b0});
    pulse_done(16'h0009, 1'b0);
    wait_show_and_score("simple");
    check("simple_state_show", {29'd0, state}, 32'd4);

    // Clear from SHOW
    c0 = clr_cnt;
    press(4'hE);
    @(negedge clk);
    check("e_state", {29'd0, state}, 32'd0);
    check("e_result_valid", {31'd0, result_valid}, 32'd0);
    check("e_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    check("e_clr_pulses", clr_cnt - c0, 32'd1);

    // Held key counts once
    c0 = clr_cnt;
    operand = 8'h22;
    key_val = 4'hA;
    key_trig = 1'b1;
    repeat (10) @(negedge clk);
    key_trig = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_clr_pulses", clr_cnt - c0, 32'd1);
    check("hold_state", {29'd0, state}, 32'd1);

    // Function change in S_B
    c0 = clr_cnt;
    press(4'hA);
    @(negedge clk);
    check("fn_a_op", {31'd0, alu_op}, 32'd0);
    press(4'hB);
    repeat (2) @(negedge clk);
    check("fn_b_op", {31'd0, alu_op}, 32'd1);
    check("fn_state", {29'd0, state}, 32'd1);
    check("fn_no_clr", clr_cnt - c0, 32'd0);
    check("fn_alu_a_kept", {24'd0, alu_a}, 32'h22);

    // Timeout with TIMEOUT = 16
    press(4'hF);
    sb.push_back('{res: 16'h0000, er: 1'b1});
    @(negedge clk);
    check("to_state_start", {29'd0, state}, 32'd2);
    wait_cycles = 0;
    for (int i = 0; i < 100 && state != 3'd4; i++) begin
      @(negedge clk);
      if (state == 3'd3) wait_cycles++;
    end
    check("to_wait_cycles", wait_cycles, 32'd16);
    wait_show_and_score("timeout");
    pulse_done(16'h0055, 1'b0);
    @(negedge clk);
    check("to_late_result", {16'd0, result}, 32'd0);
    check("to_late_err", {31'd0, err}, 32'd1);
    check("to_late_state", {29'd0, state}, 32'd4);

    // Clear in the same cycle as done
    press(4'hE);
    @(negedge clk);
    operand = 8'h03;
    press(4'hA);
    @(negedge clk);
    operand = 8'h04;
    press(4'hF);
    repeat (2) @(negedge clk);
    check("cd_in_wait", {29'd0, state}, 32'd3);
    c0 = clr_cnt;
    key_val  = 4'hE;
    key_trig = 1'b1;
    @(negedge clk);
    key_trig   = 1'b0;
    alu_result = 16'h1234;
    alu_err    = 1'b0;
    alu_done   = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    check("cd_state", {29'd0, state}, 32'd0);
    check("cd_result", {16'd0, result}, 32'd0);
    check("cd_result_valid", {31'd0, result_valid}, 32'd0);
    check("cd_entry_clr", {31'd0, entry_clr}, 32'd1);
    repeat (3) @(negedge clk);
    check("cd_clr_pulses", clr_cnt - c0, 32'd1);
    check("cd_stays_a", {29'd0, state}, 32'd0);

    // Asynchronous reset in the middle of S_WAIT
    operand = 8'h05;
    press(4'hA);
    @(negedge clk);
    press(4'hF);
    repeat (3) @(negedge clk);
    check("rw_in_wait", {29'd0, state}, 32'd3);
    reset = 1'b0;
    #1;
    check("rw_state", {29'd0, state}, 32'd0);
    check("rw_outputs", {alu_a, alu_b, 7'd0, alu_op, 4'd0, alu_start, entry_clr, result_valid, err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pulse_done(16'h0077, 1'b1);
    repeat (2) @(negedge clk);
    check("rw_done_ignored_state", {29'd0, state}, 32'd0);
    check("rw_done_ignored_result", {16'd0, result}, 32'd0);
    check("rw_done_ignored_flags", {30'd0, result_valid, err}, 32'd0);

    // Pulse-shape summary
    check("start_pulse_count", start_cnt, 32'd4);
    check("clr_start_overlap", overlap_cnt, 32'd0);
    check("pulse_longer_than_one", long_cnt, 32'd0);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
